// File: rtl/uart_hid_keyer_pkg.sv
// Shared HID constants, state encodings and the ASCII-to-scancode translation
// used by the UART keyboard injector.
package uart_hid_keyer_pkg;

  localparam logic [7:0] MOD_NONE   = 8'h00;
  localparam logic [7:0] MOD_LSHIFT = 8'h02;

  localparam logic [7:0] KEY_NONE      = 8'h00;
  localparam logic [7:0] KEY_A         = 8'h04;
  localparam logic [7:0] KEY_1         = 8'h1E;
  localparam logic [7:0] KEY_0         = 8'h27;
  localparam logic [7:0] KEY_ENTER     = 8'h28;
  localparam logic [7:0] KEY_BACKSPACE = 8'h2A;
  localparam logic [7:0] KEY_TAB       = 8'h2B;
  localparam logic [7:0] KEY_SPACE     = 8'h2C;
  localparam logic [7:0] KEY_MINUS     = 8'h2D;

  typedef enum logic [1:0] {
    USB_NONE    = 2'd0,
    USB_KBD     = 2'd1,
    USB_MOUSE   = 2'd2,
    USB_GAMEPAD = 2'd3
  } usb_type_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HOLD,
    ST_RELEASE,
    ST_GAP
  } rpt_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] mod;
    logic [7:0] code;
  } hid_key_t;

  // Inverse of the scancode-to-ASCII helper; valid=0 marks an unmapped byte.
  function automatic hid_key_t ascii_to_hid(input logic [7:0] c);
    hid_key_t k;
    k = '0;
    if (c >= 8'h61 && c <= 8'h7A) begin
      k.valid = 1'b1;
      k.code  = KEY_A + (c - 8'h61);
    end else if (c >= 8'h41 && c <= 8'h5A) begin
      k.valid = 1'b1;
      k.code  = KEY_A + (c - 8'h41);
      k.mod   = MOD_LSHIFT;
    end else if (c >= 8'h31 && c <= 8'h39) begin
      k.valid = 1'b1;
      k.code  = KEY_1 + (c - 8'h31);
    end else begin
      k.valid = 1'b1;
      case (c)
        8'h30:        k.code = KEY_0;
        8'h0A, 8'h0D: k.code = KEY_ENTER;
        8'h08:        k.code = KEY_BACKSPACE;
        8'h09:        k.code = KEY_TAB;
        8'h20:        k.code = KEY_SPACE;
        8'h2D:        k.code = KEY_MINUS;
        8'h21: begin
          k.code = KEY_1;
          k.mod  = MOD_LSHIFT;
        end
        default:      k.valid = 1'b0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/uart_hid_keyer_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling and stop-bit check.
module uart_rx_byte
  import uart_hid_keyer_pkg::*;
#(
  parameter int unsigned DIV = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;

  rx_state_e     state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        // A start bit that is high again at mid-bit was a glitch.
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s2, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s2) begin
              valid <= 1'b1;
              data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_hid_keyer.sv
// UART-to-HID keyboard injector: buffers received bytes and emits a press
// report followed by a release report for every mapped character.
module uart_hid_keyer
  import uart_hid_keyer_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 12000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned HOLD_CYCLES = 120000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [1:0] usb_type,
  output logic       usb_report,
  output logic [7:0] key_modifiers,
  output logic [7:0] key1,
  output logic [7:0] key2,
  output logic [7:0] key3,
  output logic [7:0] key4,
  output logic       busy,
  output logic       rx_error
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW  = $clog2(HOLD_CYCLES + 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (uart_rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_frame_err)
  );

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nxt;
  logic          empty, full, push, pop, fsm_active_nxt, tmr_done;
  hid_key_t      head_key;
  rpt_state_e    state;
  logic [TW-1:0] timer;
  logic [7:0]    lat_code, lat_mod;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = (state == ST_IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = rx_valid && (!full || pop);
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign head_key  = ascii_to_hid(mem[rd_ptr]);
  assign tmr_done  = (timer == TW'(HOLD_CYCLES - 1));
  assign fsm_active_nxt = (state == ST_IDLE) ? (pop && head_key.valid)
                                             : !(state == ST_GAP && tmr_done);

  assign key2 = 8'h00;
  assign key3 = 8'h00;
  assign key4 = 8'h00;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      state         <= ST_IDLE;
      timer         <= '0;
      lat_code      <= '0;
      lat_mod       <= '0;
      usb_type      <= USB_NONE;
      usb_report    <= 1'b0;
      key_modifiers <= '0;
      key1          <= '0;
      busy          <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      rx_error   <= rx_frame_err | (rx_valid & ~push);
      count      <= count_nxt;
      busy       <= (count_nxt != '0) || fsm_active_nxt;
      usb_report <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case (state)
        // Unmapped heads are popped silently without leaving IDLE.
        ST_IDLE: begin
          if (pop && head_key.valid) begin
            lat_code <= head_key.code;
            lat_mod  <= head_key.mod;
            state    <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          usb_report    <= 1'b1;
          key1          <= lat_code;
          key_modifiers <= lat_mod;
          usb_type      <= USB_KBD;
          timer         <= '0;
          state         <= ST_HOLD;
        end
        ST_HOLD: begin
          if (tmr_done) state <= ST_RELEASE;
          else          timer <= timer + TW'(1);
        end
        ST_RELEASE: begin
          usb_report    <= 1'b1;
          key1          <= KEY_NONE;
          key_modifiers <= MOD_NONE;
          timer         <= '0;
          state         <= ST_GAP;
        end
        ST_GAP: begin
          if (tmr_done) state <= ST_IDLE;
          else          timer <= timer + TW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hid_keyer.sv
// Directed bench for uart_hid_keyer: expected report stream checked every cycle.
module tb_uart_hid_keyer;

  localparam int unsigned DIV  = 10;
  localparam int unsigned HOLD = 600;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rx = 1'b1;
  logic [1:0] usb_type;
  logic       usb_report;
  logic [7:0] key_modifiers, key1, key2, key3, key4;
  logic       busy, rx_error;

  uart_hid_keyer #(
    .CLK_FREQ    (1152000),
    .BAUD        (115200),
    .HOLD_CYCLES (HOLD),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rx       (uart_rx),
    .usb_type      (usb_type),
    .usb_report    (usb_report),
    .key_modifiers (key_modifiers),
    .key1          (key1),
    .key2          (key2),
    .key3          (key3),
    .key4          (key4),
    .busy          (busy),
    .rx_error      (rx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [7:0] mod;
  } rep_t;

  rep_t       exp_q[$];
  int         press_t[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;
  int         n_rxerr = 0;
  int         last_press = 0;
  int         last_rel = 0;
  bit         have_rel = 0;
  logic [7:0] m_key = 8'h00;
  logic [7:0] m_mod = 8'h00;
  logic [1:0] m_type = 2'd0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference stream: every strobe must match the next queued report.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      m_key = 8'h00; m_mod = 8'h00; m_type = 2'd0; have_rel = 0;
    end else begin
      if (rx_error) n_rxerr++;
      if (usb_report) begin
        chk("report_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          rep_t e;
          e = exp_q.pop_front();
          if (e.code != 8'h00) begin
            m_type = 2'd1;
            if (have_rel) chk("gap_min", 64'((cyc - last_rel) >= int'(HOLD + 2)), 64'd1);
            press_t.push_back(cyc);
            last_press = cyc;
          end else begin
            chk("hold_len", 64'(cyc - last_press), 64'(HOLD + 1));
            last_rel = cyc;
            have_rel = 1;
          end
          m_key = e.code;
          m_mod = e.mod;
        end
      end
      chk("outputs", {usb_type, key_modifiers, key1, key2, key3, key4},
                     {m_type, m_mod, m_key, 24'h0});
    end
  end

  task automatic push_pair(input logic [7:0] code, input logic [7:0] mod);
    rep_t p, r;
    p.code = code; p.mod = mod;
    r.code = 8'h00; r.mod = 8'h00;
    exp_q.push_back(p);
    exp_q.push_back(r);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 uart_rx = frame[i];
      repeat (DIV - 1) @(posedge clk);
    end
    @(posedge clk); #1 uart_rx = 1'b1;
  endtask

  task automatic finish_test(input string name);
    int b;
    b = 20000;
    while (exp_q.size() != 0 && b > 0) begin @(posedge clk); b--; end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    b = 3 * HOLD;
    @(posedge clk); #1;
    while (busy && b > 0) begin @(posedge clk); #1; b--; end
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  int t0, e0, sp;

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_out", {usb_type, usb_report, key_modifiers, key1, key2, key3, key4, busy, rx_error}, 64'd0);
    resetn = 1'b1;
    repeat (5) @(posedge clk);

    // 'a'
    press_t.delete(); e0 = n_rxerr;
    push_pair(8'h04, 8'h00);
    t0 = cyc;
    send_byte(8'h61, 1);
    finish_test("a");
    chk("a_latency", 64'(press_t.size() == 1 && (press_t[0] - t0) >= 95 && (press_t[0] - t0) <= 110), 64'd1);
    chk("a_rel_spacing", 64'(last_rel - last_press), 64'd601);
    chk("a_type", 64'(usb_type), 64'd1);
    chk("a_key1_after", {key_modifiers, key1}, 64'h0);
    chk("a_rxerr", 64'(n_rxerr - e0), 64'd0);

    // "A!" back to back
    press_t.delete(); e0 = n_rxerr;
    push_pair(8'h04, 8'h02);
    push_pair(8'h1E, 8'h02);
    send_byte(8'h41, 1);
    send_byte(8'h21, 1);
    finish_test("Abang");
    sp = (press_t.size() >= 2) ? press_t[1] - press_t[0] : -1;
    chk("Abang_spacing", 64'(sp), 64'd1203);

    // unmapped 0x7E then CR
    press_t.delete(); e0 = n_rxerr;
    push_pair(8'h28, 8'h00);
    send_byte(8'h7E, 1);
    send_byte(8'h0D, 1);
    finish_test("tilde_cr");
    chk("tilde_cr_presses", 64'(press_t.size()), 64'd1);
    chk("tilde_cr_rxerr", 64'(n_rxerr - e0), 64'd0);

    // framing error
    press_t.delete(); e0 = n_rxerr;
    send_byte(8'h61, 0);
    repeat (50) @(posedge clk);
    #1 chk("frame_rxerr", 64'(n_rxerr - e0), 64'd1);
    chk("frame_busy", 64'(busy), 64'd0);
    chk("frame_presses", 64'(press_t.size()), 64'd0);

    // "abcdef" during the first hold: 'f' overruns
    press_t.delete(); e0 = n_rxerr;
    push_pair(8'h04, 8'h00);
    push_pair(8'h05, 8'h00);
    push_pair(8'h06, 8'h00);
    push_pair(8'h07, 8'h00);
    push_pair(8'h08, 8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'h61 + 8'(i), 1);
    finish_test("abcdef");
    chk("abcdef_presses", 64'(press_t.size()), 64'd5);
    sp = (press_t.size() >= 5) ? press_t[4] - press_t[0] : -1;
    chk("abcdef_spacing", 64'(sp), 64'd4812);
    chk("abcdef_rxerr", 64'(n_rxerr - e0), 64'd1);

    // 3-cycle glitch
    press_t.delete(); e0 = n_rxerr;
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (200) @(posedge clk);
    #1 chk("glitch_rxerr", 64'(n_rxerr - e0), 64'd0);
    chk("glitch_busy", 64'(busy), 64'd0);
    chk("glitch_presses", 64'(press_t.size()), 64'd0);

    // reset during HOLD: no release afterwards
    press_t.delete();
    push_pair(8'h1D, 8'h00);
    send_byte(8'h7A, 1);
    t0 = 5000;
    while (press_t.size() == 0 && t0 > 0) begin @(posedge clk); t0--; end
    chk("z_pressed", 64'(press_t.size()), 64'd1);
    repeat (100) @(posedge clk);
    #1 chk("z_busy_hold", 64'(busy), 64'd1);
    exp_q.delete();
    resetn = 1'b0;
    #1 chk("z_reset_out", {usb_type, usb_report, key_modifiers, key1, busy, rx_error}, 64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2 * HOLD + 50) @(posedge clk);
    #1 chk("z_post_reset", {usb_type, key_modifiers, key1, busy}, 64'd0);
    chk("z_no_release", 64'(press_t.size()), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
